// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the memory BIST engine.
// Bit e of each table describes element e (M0..M5).
package mbist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int         NUM_ELEM  = 6;
    localparam logic [2:0] LAST_ELEM = 3'd5;

    localparam logic [NUM_ELEM-1:0] ELEM_DOWN    = 6'b111000;
    localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
    localparam logic [NUM_ELEM-1:0] OP0_READ     = 6'b111110;
    localparam logic [NUM_ELEM-1:0] OP0_INV      = 6'b010100;
    localparam logic [NUM_ELEM-1:0] OP1_INV      = 6'b001010;

    function automatic logic elem_down(input logic [2:0] e);
        return ELEM_DOWN[e];
    endfunction

    function automatic logic op_last(input logic [2:0] e, input logic op);
        return op || !ELEM_TWO_OPS[e];
    endfunction

    function automatic logic op_read(input logic [2:0] e, input logic op);
        return !op && OP0_READ[e];
    endfunction

    function automatic logic op_inv(input logic [2:0] e, input logic op);
        return op ? OP1_INV[e] : OP0_INV[e];
    endfunction

    // Bit i of background k: zero for k=0, else runs of 2**(k-1) zeros then ones.
    function automatic logic bg_pattern(input int unsigned k, input int unsigned i);
        return (k != 0) && (((i >> (k - 1)) & 1) != 0);
    endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Read-latency delay line carrying expected data and op tags, plus the
// miscompare counter and first-failure log.
module mbist_cmp_pipe #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int BG_W   = 2,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        elem,
    input  logic [BG_W-1:0]   bg,
    input  logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [2:0]        first_fail_elem,
    output logic [BG_W-1:0]   first_fail_bg,
    output logic              fail_any
);

    logic [RD_LAT-1:0] vld;
    logic [DATA_W-1:0] exp_q  [RD_LAT];
    logic [ADDR_W-1:0] addr_q [RD_LAT];
    logic [2:0]        elem_q [RD_LAT];
    logic [BG_W-1:0]   bg_q   [RD_LAT];
    logic              miss;

    assign miss     = vld[RD_LAT-1] && (rdata != exp_q[RD_LAT-1]) && !flush;
    assign fail_any = (fail_cnt != '0) || miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
                elem_q[i] <= '0;
                bg_q[i]   <= '0;
            end
        end else begin
            vld[0]    <= push && !flush && !clear;
            exp_q[0]  <= exp_data;
            addr_q[0] <= addr;
            elem_q[0] <= elem;
            bg_q[0]   <= bg;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i]    <= vld[i-1] && !flush && !clear;
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
                elem_q[i] <= elem_q[i-1];
                bg_q[i]   <= bg_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt        <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
            first_fail_bg   <= '0;
        end else if (clear) begin
            fail_cnt        <= '0;
            first_fail_addr <= '0;
            first_fail_elem <= '0;
            first_fail_bg   <= '0;
        end else if (miss) begin
            if (fail_cnt != '1)
                fail_cnt <= fail_cnt + 1'b1;
            if (fail_cnt == '0) begin
                first_fail_addr <= addr_q[RD_LAT-1];
                first_fail_elem <= elem_q[RD_LAT-1];
                first_fail_bg   <= bg_q[RD_LAT-1];
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: walks backgrounds/elements/addresses/ops one op per
// cycle and drives registered SRAM controls; compare/logging is in mbist_cmp_pipe.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter  int ADDR_W = 6,
    parameter  int DATA_W = 8,
    parameter  int NUM_BG = 2,
    parameter  int RD_LAT = 1,
    parameter  int CNT_W  = 8,
    localparam int BG_W   = $clog2(NUM_BG) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              bist_active,
    output logic              mem_cs,
    output logic              mem_rwbar,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [2:0]        first_fail_elem,
    output logic [BG_W-1:0]   first_fail_bg
);

    state_e            state, state_nxt;
    logic [BG_W-1:0]   bg, bg_nxt;
    logic [2:0]        elem, elem_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt, addr_nxt;
    logic              op, op_nxt;
    logic [1:0]        drain, drain_nxt;
    logic [DATA_W-1:0] d_nxt;
    logic              run_start, kill, fail_any;

    assign busy        = (state == RUN) || (state == DRAIN);
    assign bist_active = (state != IDLE);
    assign done        = (state == DONE);
    assign kill        = abort && busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bg_nxt    = bg;
        elem_nxt  = elem;
        idx_nxt   = idx;
        op_nxt    = op;
        drain_nxt = drain;
        run_start = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                    bg_nxt    = '0;
                    elem_nxt  = '0;
                    idx_nxt   = '0;
                    op_nxt    = 1'b0;
                    run_start = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (!op_last(elem, op)) begin
                    op_nxt = 1'b1;
                end else begin
                    op_nxt  = 1'b0;
                    idx_nxt = idx + 1'b1;
                    if (idx == '1) begin
                        if (elem != LAST_ELEM) begin
                            elem_nxt = elem + 3'd1;
                        end else begin
                            elem_nxt = '0;
                            if (bg != BG_W'(NUM_BG - 1)) begin
                                bg_nxt = bg + 1'b1;
                            end else begin
                                state_nxt = DRAIN;
                                drain_nxt = 2'(RD_LAT - 1);
                            end
                        end
                    end
                end
            end
            DRAIN: begin
                if (abort)             state_nxt = IDLE;
                else if (drain == '0)  state_nxt = DONE;
                else                   drain_nxt = drain - 2'd1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address is an up-counter index; descending elements use its complement.
    assign addr_nxt = elem_down(elem_nxt) ? ~idx_nxt : idx_nxt;

    always_comb begin
        d_nxt = '0;
        for (int i = 0; i < DATA_W; i++)
            d_nxt[i] = bg_pattern(32'(bg_nxt), i) ^ op_inv(elem_nxt, op_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg        <= '0;
            elem      <= '0;
            idx       <= '0;
            op        <= 1'b0;
            drain     <= '0;
            mem_cs    <= 1'b0;
            mem_rwbar <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pass      <= 1'b0;
        end else begin
            bg    <= bg_nxt;
            elem  <= elem_nxt;
            idx   <= idx_nxt;
            op    <= op_nxt;
            drain <= drain_nxt;
            if (state_nxt == RUN) begin
                mem_cs    <= 1'b1;
                mem_rwbar <= op_read(elem_nxt, op_nxt);
                mem_addr  <= addr_nxt;
                mem_wdata <= d_nxt;
            end else begin
                mem_cs    <= 1'b0;
                mem_rwbar <= 1'b1;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
            // fail_any folds in the compare landing on this same edge.
            if (run_start || kill)
                pass <= 1'b0;
            else if (state == DRAIN && state_nxt == DONE)
                pass <= !fail_any;
        end
    end

    mbist_cmp_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BG_W   (BG_W),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (run_start),
        .flush           (kill),
        .push            (mem_cs && mem_rwbar),
        .exp_data        (mem_wdata),
        .addr            (mem_addr),
        .elem            (elem),
        .bg              (bg),
        .rdata           (mem_rdata),
        .fail_cnt        (fail_cnt),
        .first_fail_addr (first_fail_addr),
        .first_fail_elem (first_fail_elem),
        .first_fail_bg   (first_fail_bg),
        .fail_any        (fail_any)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (1 bg/latency 1, 2 bg/latency 2/2-bit count)
// each driving a small SRAM model with selectable stuck-at faults.
module tb_mbist_march_ctrl;

    logic clk = 1'b0;
    logic rst_n, abort, start_a, start_b;

    logic       bist_active_a, mem_cs_a, mem_rwbar_a, busy_a, done_a, pass_a;
    logic [1:0] mem_addr_a, ffa_a;
    logic [7:0] mem_wdata_a, mem_rdata_a, fail_cnt_a;
    logic [2:0] ffe_a;
    logic [0:0] ffb_a;

    logic       bist_active_b, mem_cs_b, mem_rwbar_b, busy_b, done_b, pass_b;
    logic [1:0] mem_addr_b, ffa_b, fail_cnt_b, ffb_b;
    logic [7:0] mem_wdata_b, mem_rdata_b, rd_b1;
    logic [2:0] ffe_b;

    logic [7:0] ram_a [4];
    logic [7:0] ram_b [4];
    int fault_a, fault_b;
    int total = 0;
    int bad = 0;
    int tr_addr [100];
    int tr_rw   [100];
    int tr_wd   [100];

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8), .NUM_BG(1), .RD_LAT(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
        .bist_active(bist_active_a), .mem_cs(mem_cs_a), .mem_rwbar(mem_rwbar_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_cnt(fail_cnt_a),
        .first_fail_addr(ffa_a), .first_fail_elem(ffe_a), .first_fail_bg(ffb_a));

    mbist_march_ctrl #(.ADDR_W(2), .DATA_W(8), .NUM_BG(2), .RD_LAT(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
        .bist_active(bist_active_b), .mem_cs(mem_cs_b), .mem_rwbar(mem_rwbar_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_cnt(fail_cnt_b),
        .first_fail_addr(ffa_b), .first_fail_elem(ffe_b), .first_fail_bg(ffb_b));

    // mode 1: bit 0 of address 2 stuck-at-1; mode 2: every bit stuck-at-0
    function automatic logic [7:0] faulty(input int mode, input logic [1:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (mode == 1 && a == 2'd2) r[0] = 1'b1;
        if (mode == 2) r = 8'h00;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_cs_a) begin
            if (mem_rwbar_a) mem_rdata_a <= faulty(fault_a, mem_addr_a, ram_a[mem_addr_a]);
            else             ram_a[mem_addr_a] <= mem_wdata_a;
        end
    end

    always @(posedge clk) begin
        mem_rdata_b <= rd_b1;
        if (mem_cs_b) begin
            if (mem_rwbar_b) rd_b1 <= faulty(fault_b, mem_addr_b, ram_b[mem_addr_b]);
            else             ram_b[mem_addr_b] <= mem_wdata_b;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_dut(input int sel, input int restart_at, output int busy_n, output int done_n);
        bit fin;
        fin = 1'b0;
        busy_n = 0;
        done_n = 0;
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if ((sel == 0) ? busy_a : busy_b) begin
                if (busy_n < 100) begin
                    tr_addr[busy_n] = (sel == 0) ? int'(mem_addr_a)  : int'(mem_addr_b);
                    tr_rw[busy_n]   = (sel == 0) ? int'(mem_rwbar_a) : int'(mem_rwbar_b);
                    tr_wd[busy_n]   = (sel == 0) ? int'(mem_wdata_a) : int'(mem_wdata_b);
                end
                busy_n++;
            end
            if ((sel == 0) ? done_a : done_b) done_n++;
            if (!((sel == 0) ? bist_active_a : bist_active_b)) begin
                fin = 1'b1;
            end else begin
                if (c == restart_at) begin
                    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
                end
                @(negedge clk);
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        if (!fin) check("run_timeout", 0, 1);
    endtask

    typedef struct {
        int sel; int fault; int restart_at;
        int busy; int cnt; int pass; int faddr; int felem; int fbg;
    } vec_t;
    vec_t vecs [5];

    int exp_addr_a [40] = '{0,1,2,3, 0,0,1,1,2,2,3,3, 0,0,1,1,2,2,3,3,
                            3,3,2,2,1,1,0,0, 3,3,2,2,1,1,0,0, 3,2,1,0};
    int exp_rw_a [40]   = '{0,0,0,0, 1,0,1,0,1,0,1,0, 1,0,1,0,1,0,1,0,
                            1,0,1,0,1,0,1,0, 1,0,1,0,1,0,1,0, 1,1,1,1};
    int exp_wd_a [40]   = '{0,0,0,0, 0,255,0,255,0,255,0,255, 255,0,255,0,255,0,255,0,
                            0,255,0,255,0,255,0,255, 255,0,255,0,255,0,255,0, 0,0,0,0};
    // {cycle, addr, rwbar, wdata} spot checks for the two-background run
    int spot_b [8][4]   = '{'{0,0,0,8'h00}, '{3,3,0,8'h00}, '{40,0,0,8'hAA}, '{43,3,0,8'hAA},
                            '{44,0,1,8'hAA}, '{45,0,0,8'h55}, '{60,3,1,8'hAA}, '{79,0,1,8'hAA}};

    initial begin
        int bn, dn;
        vecs[0] = '{0, 0,  5, 41, 0, 1, 0, 0, 0};
        vecs[1] = '{0, 1, -1, 41, 3, 0, 2, 1, 0};
        vecs[2] = '{0, 0, -1, 41, 0, 1, 0, 0, 0};
        vecs[3] = '{1, 0, -1, 82, 0, 1, 0, 0, 0};
        vecs[4] = '{1, 2, -1, 82, 3, 0, 0, 2, 0};

        rst_n = 1'b0; abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
        fault_a = 0; fault_b = 0;
        #12;
        check("rst_rwbar_a",  mem_rwbar_a, 1);
        check("rst_cs_a",     mem_cs_a, 0);
        check("rst_active_a", bist_active_a, 0);
        check("rst_pass_a",   pass_a, 0);
        check("rst_cnt_a",    fail_cnt_a, 0);
        check("rst_rwbar_b",  mem_rwbar_b, 1);
        check("rst_busy_b",   busy_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].sel == 0) fault_a = vecs[v].fault; else fault_b = vecs[v].fault;
            run_dut(vecs[v].sel, vecs[v].restart_at, bn, dn);
            check($sformatf("v%0d_busy_cycles", v), bn, vecs[v].busy);
            check($sformatf("v%0d_done_pulses", v), dn, 1);
            check($sformatf("v%0d_fail_cnt", v), vecs[v].sel ? int'(fail_cnt_b) : int'(fail_cnt_a), vecs[v].cnt);
            check($sformatf("v%0d_pass", v), vecs[v].sel ? int'(pass_b) : int'(pass_a), vecs[v].pass);
            check($sformatf("v%0d_ff_addr", v), vecs[v].sel ? int'(ffa_b) : int'(ffa_a), vecs[v].faddr);
            check($sformatf("v%0d_ff_elem", v), vecs[v].sel ? int'(ffe_b) : int'(ffe_a), vecs[v].felem);
            check($sformatf("v%0d_ff_bg", v), vecs[v].sel ? int'(ffb_b) : int'(ffb_a), vecs[v].fbg);
            if (v == 0) begin
                for (int i = 0; i < 40; i++) begin
                    check($sformatf("trace_a_addr[%0d]", i), tr_addr[i], exp_addr_a[i]);
                    check($sformatf("trace_a_rw[%0d]", i), tr_rw[i], exp_rw_a[i]);
                    check($sformatf("trace_a_wd[%0d]", i), tr_wd[i], exp_wd_a[i]);
                end
            end
            if (v == 3) begin
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("trace_b_addr@%0d", spot_b[i][0]), tr_addr[spot_b[i][0]], spot_b[i][1]);
                    check($sformatf("trace_b_rw@%0d", spot_b[i][0]), tr_rw[spot_b[i][0]], spot_b[i][2]);
                    check($sformatf("trace_b_wd@%0d", spot_b[i][0]), tr_wd[spot_b[i][0]], spot_b[i][3]);
                end
            end
        end

        // abort at run cycle 10, after the first M1 failure on address 2 has been logged
        fault_a = 1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_active", bist_active_a, 0);
        check("abort_busy",   busy_a, 0);
        check("abort_cs",     mem_cs_a, 0);
        check("abort_pass",   pass_a, 0);
        check("abort_cnt",    fail_cnt_a, 1);
        check("abort_ffaddr", ffa_a, 2);
        dn = 0;
        repeat (5) begin
            if (done_a) dn++;
            @(negedge clk);
        end
        check("abort_no_done", dn, 0);
        fault_a = 0;
        run_dut(0, -1, bn, dn);
        check("after_abort_busy", bn, 41);
        check("after_abort_pass", pass_a, 1);

        // start and abort together while idle
        @(negedge clk); start_a = 1'b1; abort = 1'b1;
        @(negedge clk); start_a = 1'b0; abort = 1'b0;
        check("start_abort_idle_active", bist_active_a, 0);
        check("start_abort_idle_pass",   pass_a, 1);

        // asynchronous reset mid-run
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs",     mem_cs_a, 0);
        check("arst_active", bist_active_a, 0);
        check("arst_busy",   busy_a, 0);
        check("arst_rwbar",  mem_rwbar_a, 1);
        check("arst_pass",   pass_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_dut(0, -1, bn, dn);
        check("after_arst_busy", bn, 41);
        check("after_arst_pass", pass_a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
